// File: rtl/sys_top.sv
// UART-controlled register file and ALU: decodes serial command frames, updates a
// 16x8 register file, and returns read data / ALU results through a byte FIFO.
module sys_top #(
    parameter int PRESCALE      = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int RF_DEPTH      = 16,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic REF_CLK,
    input  logic RST,
    input  logic UART_RX_IN,
    output logic UART_TX_OUT,
    output logic PARITY_ERROR,
    output logic FRAM_ERROR
);
    localparam int AW         = $clog2(RF_DEPTH);
    localparam int FW         = $clog2(TX_FIFO_DEPTH);
    localparam int CW         = $clog2(PRESCALE);
    localparam int RW         = 2 * DATA_WIDTH;
    localparam int FRAME_BITS = DATA_WIDTH + 3;
    localparam int BW         = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] SMP0    = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] SMP1    = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] SMP2    = CW'(PRESCALE / 2 + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'('hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'('hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'('hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'('hDD);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, A_OP, B_OP, FUNC} cmdState_t;

    logic [1:0]            rxSync_q;
    logic                  rxPrev_q, rxBusy_q, rxPar_q, rxValid_q, parErr_q, framErr_q;
    logic [CW-1:0]         rxCnt_q;
    logic [BW-1:0]         rxBit_q;
    logic [DATA_WIDTH-1:0] rxShift_q;
    logic [1:0]            rxSmp_q;
    logic                  rxIn, rxMaj;

    assign rxIn  = rxSync_q[1];
    assign rxMaj = (rxSmp_q[0] & rxSmp_q[1]) | (rxSmp_q[0] & rxIn) | (rxSmp_q[1] & rxIn);

    // Receiver: bit 0 is the start bit, then data, parity, and stop at FRAME_BITS-1.
    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            rxSync_q  <= '1;
            rxPrev_q  <= 1'b1;
            rxBusy_q  <= 1'b0;
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxShift_q <= '0;
            rxPar_q   <= 1'b0;
            rxSmp_q   <= '0;
            rxValid_q <= 1'b0;
            parErr_q  <= 1'b0;
            framErr_q <= 1'b0;
        end else begin
            rxSync_q  <= {rxSync_q[0], UART_RX_IN};
            rxPrev_q  <= rxIn;
            rxValid_q <= 1'b0;
            parErr_q  <= 1'b0;
            framErr_q <= 1'b0;
            if (!rxBusy_q) begin
                if (rxPrev_q && !rxIn) begin
                    rxBusy_q <= 1'b1;
                    rxCnt_q  <= CW'(1);
                    rxBit_q  <= '0;
                end
            end else begin
                if (rxCnt_q == CNT_MAX) begin
                    rxCnt_q <= '0;
                    rxBit_q <= rxBit_q + BW'(1);
                end else begin
                    rxCnt_q <= rxCnt_q + CW'(1);
                end
                if (rxCnt_q == SMP0) rxSmp_q[0] <= rxIn;
                if (rxCnt_q == SMP1) rxSmp_q[1] <= rxIn;
                if (rxCnt_q == SMP2) begin
                    if (rxBit_q == '0) begin
                        if (rxMaj) rxBusy_q <= 1'b0;
                    end else if (rxBit_q <= BW'(DATA_WIDTH)) begin
                        rxShift_q <= {rxMaj, rxShift_q[DATA_WIDTH-1:1]};
                    end else if (rxBit_q == BW'(DATA_WIDTH + 1)) begin
                        rxPar_q <= rxMaj;
                    end else begin
                        rxBusy_q  <= 1'b0;
                        parErr_q  <= ^{rxShift_q, rxPar_q};
                        framErr_q <= !rxMaj;
                        rxValid_q <= !(^{rxShift_q, rxPar_q}) && rxMaj;
                    end
                end
            end
        end
    end

    assign PARITY_ERROR = parErr_q;
    assign FRAM_ERROR   = framErr_q;

    cmdState_t             state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d, rfWAddr;
    logic                  rfWe, rdPush, aluPush;
    logic [DATA_WIDTH-1:0] rf_q [RF_DEPTH];
    logic [RW-1:0]         opA, opB, aluRes;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rfWe    = 1'b0;
        rfWAddr = addr_q;
        rdPush  = 1'b0;
        aluPush = 1'b0;
        if (parErr_q || framErr_q) begin
            state_d = IDLE;
        end else if (rxValid_q) begin
            unique case (state_q)
                IDLE: begin
                    if (rxShift_q == CMD_WR)          state_d = WR_ADDR;
                    else if (rxShift_q == CMD_RD)     state_d = RD_ADDR;
                    else if (rxShift_q == CMD_ALU_OP) state_d = A_OP;
                    else if (rxShift_q == CMD_ALU)    state_d = FUNC;
                end
                WR_ADDR: begin
                    addr_d  = rxShift_q[AW-1:0];
                    state_d = WR_DATA;
                end
                WR_DATA: begin
                    rfWe    = 1'b1;
                    state_d = IDLE;
                end
                RD_ADDR: begin
                    rdPush  = 1'b1;
                    state_d = IDLE;
                end
                A_OP: begin
                    rfWe    = 1'b1;
                    rfWAddr = AW'(0);
                    state_d = B_OP;
                end
                B_OP: begin
                    rfWe    = 1'b1;
                    rfWAddr = AW'(1);
                    state_d = FUNC;
                end
                FUNC: begin
                    aluPush = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign opA = RW'(rf_q[0]);
    assign opB = RW'(rf_q[1]);

    always_comb begin
        aluRes = '0;
        case (rxShift_q[3:0])
            4'd0:    aluRes = opA + opB;
            4'd1:    aluRes = opA - opB;
            4'd2:    aluRes = opA * opB;
            4'd3:    aluRes = (opB == '0) ? '0 : opA / opB;
            4'd4:    aluRes = opA & opB;
            4'd5:    aluRes = opA | opB;
            4'd6:    aluRes = RW'(~(rf_q[0] & rf_q[1]));
            4'd7:    aluRes = RW'(~(rf_q[0] | rf_q[1]));
            4'd8:    aluRes = opA ^ opB;
            4'd9:    aluRes = RW'(~(rf_q[0] ^ rf_q[1]));
            4'd10:   aluRes = RW'(opA == opB);
            4'd11:   aluRes = RW'(opA > opB);
            4'd12:   aluRes = opA >> 1;
            4'd13:   aluRes = opA << 1;
            default: aluRes = '0;
        endcase
    end

    // The high result byte is held one cycle so the FIFO needs only one write port.
    logic                  pendValid_q;
    logic [DATA_WIDTH-1:0] pendHi_q;

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pendValid_q <= 1'b0;
            pendHi_q    <= '0;
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pendValid_q <= aluPush;
            if (aluPush) pendHi_q <= aluRes[RW-1:DATA_WIDTH];
            if (rfWe) rf_q[rfWAddr] <= rxShift_q;
        end
    end

    logic                  pushEn, doPush, fifoFull, fifoEmpty, txLoad, txFrameEnd;
    logic [DATA_WIDTH-1:0] pushData, fifoOut;
    logic [DATA_WIDTH-1:0] fifo_q [TX_FIFO_DEPTH];
    logic [FW-1:0]         wPtr_q, rPtr_q;
    logic [FW:0]           count_q;

    always_comb begin
        pushEn   = 1'b0;
        pushData = pendHi_q;
        if (rdPush) begin
            pushEn   = 1'b1;
            pushData = rf_q[rxShift_q[AW-1:0]];
        end else if (aluPush) begin
            pushEn   = 1'b1;
            pushData = aluRes[DATA_WIDTH-1:0];
        end else if (pendValid_q) begin
            pushEn = 1'b1;
        end
    end

    assign fifoFull  = (count_q == (FW+1)'(TX_FIFO_DEPTH));
    assign fifoEmpty = (count_q == '0);
    assign doPush    = pushEn && !fifoFull;
    assign fifoOut   = fifo_q[rPtr_q];

    always_ff @(posedge REF_CLK) begin
        if (doPush) fifo_q[wPtr_q] <= pushData;
    end

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            wPtr_q  <= '0;
            rPtr_q  <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wPtr_q <= wPtr_q + FW'(1);
            if (txLoad) rPtr_q <= rPtr_q + FW'(1);
            count_q <= count_q + (FW+1)'(doPush) - (FW+1)'(txLoad);
        end
    end

    logic                  txBusy_q;
    logic [CW-1:0]         txCnt_q;
    logic [BW-1:0]         txBit_q;
    logic [FRAME_BITS-1:0] txShift_q;

    assign txFrameEnd = txBusy_q && (txCnt_q == CNT_MAX) && (txBit_q == BW'(FRAME_BITS - 1));
    assign txLoad     = !fifoEmpty && (!txBusy_q || txFrameEnd);

    // Reloading on the last stop-bit cycle keeps consecutive frames gap-free.
    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            txBusy_q  <= 1'b0;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= '1;
        end else if (txLoad) begin
            txBusy_q  <= 1'b1;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= {1'b1, ^fifoOut, fifoOut, 1'b0};
        end else if (txBusy_q) begin
            if (txCnt_q == CNT_MAX) begin
                txCnt_q   <= '0;
                txBit_q   <= txBit_q + BW'(1);
                txShift_q <= {1'b1, txShift_q[FRAME_BITS-1:1]};
                if (txBit_q == BW'(FRAME_BITS - 1)) txBusy_q <= 1'b0;
            end else begin
                txCnt_q <= txCnt_q + CW'(1);
            end
        end
    end

    assign UART_TX_OUT = txShift_q[0];

endmodule

// File: tb/tb_sys_top.sv
// Directed testbench for sys_top: drives UART command frames and decodes the
// serial responses with an independent frame monitor.
module tb_sys_top;
    localparam int PRESCALE   = 32;
    localparam int CLK_PERIOD = 10;
    localparam int FRAME_CYC  = 11 * PRESCALE;

    logic clk   = 1'b0;
    logic rstN  = 1'b0;
    logic rxLine = 1'b1;
    logic txOut, parityErr, framErr;

    always #(CLK_PERIOD / 2) clk = ~clk;

    sys_top #(
        .PRESCALE(PRESCALE),
        .DATA_WIDTH(8),
        .RF_DEPTH(16),
        .TX_FIFO_DEPTH(8)
    ) dut (
        .REF_CLK(clk),
        .RST(rstN),
        .UART_RX_IN(rxLine),
        .UART_TX_OUT(txOut),
        .PARITY_ERROR(parityErr),
        .FRAM_ERROR(framErr)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         startCyc;
    } frame_t;

    frame_t frames[$];
    int checks = 0;
    int failures = 0;
    int peCount = 0;
    int feCount = 0;
    int txLowCount = 0;
    int lastStopCyc = 0;

    always @(negedge clk) begin
        if (parityErr === 1'b1) peCount++;
        if (framErr === 1'b1) feCount++;
        if (txOut !== 1'b1) txLowCount++;
    end

    // Response decoder: samples each transmitted bit near its middle.
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (txOut === 1'b0) begin
                f = '0;
                f.startCyc = int'($time / CLK_PERIOD);
                repeat (PRESCALE / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (PRESCALE) @(negedge clk);
                    f.data[i] = txOut;
                end
                repeat (PRESCALE) @(negedge clk);
                f.par = txOut;
                repeat (PRESCALE) @(negedge clk);
                f.stop = txOut;
                frames.push_back(f);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic flipParity = 1'b0,
                                 input logic stopBit = 1'b1);
        logic [10:0] bits;
        bits = {stopBit, (^data) ^ flipParity, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == 10) lastStopCyc = int'($time / CLK_PERIOD);
            rxLine = bits[i];
            repeat (PRESCALE) @(negedge clk);
        end
        rxLine = 1'b1;
    endtask

    task automatic waitFrames(input int n, input int budget);
        int k;
        k = 0;
        while (frames.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("frameArrived", 32'(frames.size() >= n), 32'd1);
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] data);
        frame_t f;
        f.data = 8'hxx;
        f.par = 1'bx;
        f.stop = 1'bx;
        f.startCyc = 0;
        if (frames.size() > 0) f = frames.pop_front();
        checkOutput({tag, "_data"}, 32'(f.data), 32'(data));
        checkOutput({tag, "_parity"}, 32'(f.par), 32'(^data));
        checkOutput({tag, "_stop"}, 32'(f.stop), 32'd1);
    endtask

    initial begin
        int pe0, fe0, k;

        rstN = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("resetTx", 32'(txOut), 32'd1);
        rstN = 1'b1;
        repeat (2 * FRAME_CYC) @(negedge clk);
        checkOutput("idleTxLow", txLowCount, 0);
        checkOutput("idleParityErr", peCount, 0);
        checkOutput("idleFramErr", feCount, 0);

        // Write RF[12]=0xF0, then read it back
        applyStimulus(8'hAA);
        applyStimulus(8'h0C);
        applyStimulus(8'hF0);
        repeat (FRAME_CYC) @(negedge clk);
        checkOutput("writeNoResponse", frames.size(), 0);
        applyStimulus(8'hBB);
        applyStimulus(8'h0C);
        waitFrames(1, 3 * FRAME_CYC);
        if (frames.size() > 0)
            checkOutput("readLatency", 32'((frames[0].startCyc - lastStopCyc) <= PRESCALE / 2 + 10), 32'd1);
        checkFrame("readF0", 8'hF0);

        // ALU with operands: 5 * 6
        applyStimulus(8'hCC);
        applyStimulus(8'h05);
        applyStimulus(8'h06);
        applyStimulus(8'h02);
        waitFrames(2, 4 * FRAME_CYC);
        checkFrame("mulLo", 8'h1E);
        checkFrame("mulHi", 8'h00);
        applyStimulus(8'hBB);
        applyStimulus(8'h00);
        waitFrames(1, 3 * FRAME_CYC);
        checkFrame("rf0", 8'h05);
        applyStimulus(8'hBB);
        applyStimulus(8'h01);
        waitFrames(1, 3 * FRAME_CYC);
        checkFrame("rf1", 8'h06);

        // ALU without operands: add, then subtract with 16-bit wrap
        applyStimulus(8'hDD);
        applyStimulus(8'h00);
        waitFrames(2, 4 * FRAME_CYC);
        if (frames.size() >= 2)
            checkOutput("backToBack", frames[1].startCyc - frames[0].startCyc, FRAME_CYC);
        checkFrame("addLo", 8'h0B);
        checkFrame("addHi", 8'h00);
        applyStimulus(8'hDD);
        applyStimulus(8'h01);
        waitFrames(2, 4 * FRAME_CYC);
        checkFrame("subLo", 8'hFF);
        checkFrame("subHi", 8'hFF);

        // Division by zero after clearing RF[1]
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'hDD);
        applyStimulus(8'h03);
        waitFrames(2, 4 * FRAME_CYC);
        checkFrame("divZeroLo", 8'h00);
        checkFrame("divZeroHi", 8'h00);

        // Parity error on the command byte: discarded, address byte then ignored
        pe0 = peCount;
        fe0 = feCount;
        applyStimulus(8'hBB, 1'b1);
        applyStimulus(8'h0C);
        repeat (2 * FRAME_CYC) @(negedge clk);
        checkOutput("parityPulse", peCount - pe0, 1);
        checkOutput("parityNoFram", feCount - fe0, 0);
        checkOutput("parityNoResponse", frames.size(), 0);

        // Framing error on the address byte
        pe0 = peCount;
        fe0 = feCount;
        applyStimulus(8'hBB);
        applyStimulus(8'h0C, 1'b0, 1'b0);
        repeat (2 * FRAME_CYC) @(negedge clk);
        checkOutput("framPulse", feCount - fe0, 1);
        checkOutput("framNoParity", peCount - pe0, 0);
        checkOutput("framNoResponse", frames.size(), 0);

        // Overlapping reads: second command starts one bit time after the first
        applyStimulus(8'hBB);
        applyStimulus(8'h0C);
        repeat (PRESCALE) @(negedge clk);
        applyStimulus(8'hBB);
        applyStimulus(8'h0C);
        waitFrames(2, 4 * FRAME_CYC);
        checkFrame("overlap1", 8'hF0);
        checkFrame("overlap2", 8'hF0);

        // Reset in the middle of a response frame
        applyStimulus(8'hBB);
        applyStimulus(8'h0C);
        k = 0;
        while (txOut !== 1'b0 && k < FRAME_CYC) begin
            @(negedge clk);
            k++;
        end
        checkOutput("respStarted", 32'(txOut), 32'd0);
        repeat (3 * PRESCALE) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("resetAbortTx", 32'(txOut), 32'd1);
        @(negedge clk);
        rstN = 1'b1;
        repeat (FRAME_CYC) @(negedge clk);
        frames.delete();
        applyStimulus(8'hBB);
        applyStimulus(8'h0C);
        waitFrames(1, 3 * FRAME_CYC);
        checkFrame("rfCleared", 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sys_top.md
# sys_top

UART-controlled register-file/ALU processing block. A host sends command frames on a serial line. The block decodes them to write or read a 16×8 register file, or to run a 16-bit-result ALU operation, and returns read data and ALU results as serial frames. It is the top of the processing subsystem and sits directly on the board UART pins.

## Interface
- PRESCALE, 32 — clock cycles per UART bit; even, ≥8.
- DATA_WIDTH, 8 — UART payload and register width.
- RF_DEPTH, 16 — register-file entries; the address is the low 4 bits of the address byte.
- TX_FIFO_DEPTH, 8 — outgoing byte queue depth.
- REF_CLK  input  1  the single clock for the whole block; every register is clocked on its rising edge.
- RST  input  1  asynchronous, active-low reset.
- UART_RX_IN  input  1  serial command input; idles high.
- UART_TX_OUT  output  1  serial response output; idles high.
- PARITY_ERROR  output  1  one-cycle pulse when a received frame fails the parity check.
- FRAM_ERROR  output  1  one-cycle pulse when a received frame has a stop bit of 0.

## Operation
- Frame format, both directions:
  - 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
  - Each bit lasts PRESCALE clocks.
- RX:
  - Idle until UART_RX_IN falls.
  - Take a majority-of-3 sample around mid-bit (counts PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1).
  - If the start bit samples 1, it is a glitch: return to idle.
  - A frame with a parity error or a framing error is discarded, and the command FSM returns to IDLE.
- Command FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, A_OP, B_OP, FUNC.
  - 0xAA (register write): IDLE→WR_ADDR→WR_DATA. Sequence is address byte, then data byte; write RF[addr] ← data. No response.
  - 0xBB (register read): IDLE→RD_ADDR. Sequence is the address byte; queue RF[addr] for transmit.
  - 0xCC (ALU with operands): IDLE→A_OP→B_OP→FUNC. A is written to RF[0] and B to RF[1], then the function byte is received. The ALU computes on RF[0], RF[1]; queue the result low byte, then the high byte.
  - 0xDD (ALU, no operands): IDLE→FUNC. Same as 0xCC using the current RF[0], RF[1].
  - Any other byte received in IDLE is ignored.
- ALU (A=RF[0], B=RF[1], 16-bit unsigned result; function code is the low 4 bits of the function byte):
  - 0 A+B; 1 A−B (16-bit wrap); 2 A*B; 3 A/B (0 if B=0).
  - 4 AND; 5 OR; 6 NAND; 7 NOR; 8 XOR; 9 XNOR (logic results zero-extended to 16 bits).
  - 10 (A==B); 11 (A>B); 12 A>>1; 13 A<<1.
  - 14, 15 → 0.
- TX:
  - A byte FIFO feeds a transmitter that sends frames back-to-back while the FIFO is non-empty.
  - RX and command decode continue while TX is busy.
  - If the FIFO is full, new response bytes are dropped.
- Reset:
  - RF is all zeros, FIFO empty, FSM in IDLE.
  - UART_TX_OUT=1, PARITY_ERROR=0, FRAM_ERROR=0.
  - Reset asserted mid-frame aborts any RX or TX in progress immediately.

## Timing
- A received byte is valid 1 clock after the stop-bit sample point.
- The register write completes 1 clock after the data byte is valid.
- For 0xBB, the byte is in the FIFO ≤2 clocks after the address byte is valid.
- For 0xCC/0xDD, both result bytes are in the FIFO ≤3 clocks after the function byte is valid.
- With TX idle, the start bit of the response begins ≤4 clocks after the last command byte is valid.
- Frame spacing:
  - Consecutive TX frames have no idle bits between them.
  - The stop bit of a frame is a full PRESCALE clocks.
- A new RX start bit is accepted any time after the previous stop-bit sample.
- Host spacing between bytes of one command is unbounded; there is no timeout.
- Error pulses: PARITY_ERROR and FRAM_ERROR are asserted for exactly 1 clock, at the cycle the byte would have been valid. Both may pulse in the same cycle.

## Test plan
- Reset released, no stimulus → UART_TX_OUT stays 1; both error outputs stay 0.
- Write then read:
  - Stimulus: 0xAA, 0x0C, 0xF0, then 0xBB, 0x0C.
  - Response: one frame with data 0xF0 and parity 0.
  - No frame is sent in response to the write.
- ALU with operands:
  - Stimulus: 0xCC, A=0x05, B=0x06, func 0x02 (parity bit 1).
  - Response: frames 0x1E then 0x00.
  - RF[0]=0x05 and RF[1]=0x06 afterwards.
- ALU without operands:
  - Stimulus: 0xDD, 0x00 after the previous scenario.
  - Response: frames 0x0B then 0x00.
- Error handling:
  - 0xBB with a wrong parity bit → PARITY_ERROR pulses for 1 clock and no response is sent.
  - A frame with stop=0 → FRAM_ERROR pulses for 1 clock.
- Overlap: send 0xBB, 0x0C and, one bit time later, start sending 0xBB, 0x0C again → two 0xF0 frames are sent back-to-back and no byte is lost.
